// File: rtl/lea_128bits_divide_in_16x8_register.sv
`default_nettype none
//============================================================================
// Module  : lea_128bits_divide_in_16x8_register
// Purpose : Registers a 128-bit LEA block and presents it as 16 byte lanes.
// Revision: 1.0 - initial release
//============================================================================
module lea_128bits_divide_in_16x8_register (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [127:0] Din,
    output logic [7:0]   Dout0,
    output logic [7:0]   Dout1,
    output logic [7:0]   Dout2,
    output logic [7:0]   Dout3,
    output logic [7:0]   Dout4,
    output logic [7:0]   Dout5,
    output logic [7:0]   Dout6,
    output logic [7:0]   Dout7,
    output logic [7:0]   Dout8,
    output logic [7:0]   Dout9,
    output logic [7:0]   Dout10,
    output logic [7:0]   Dout11,
    output logic [7:0]   Dout12,
    output logic [7:0]   Dout13,
    output logic [7:0]   Dout14,
    output logic [7:0]   Dout15,
    output logic         valid
);

    // Packed as [lane][bit], so lane k lines up with Din[8k+7:8k].
    logic [15:0][7:0] r_lanes;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_lanes <= Din;
            r_valid <= 1'b1;
        end
    end

    assign Dout0  = r_lanes[0];
    assign Dout1  = r_lanes[1];
    assign Dout2  = r_lanes[2];
    assign Dout3  = r_lanes[3];
    assign Dout4  = r_lanes[4];
    assign Dout5  = r_lanes[5];
    assign Dout6  = r_lanes[6];
    assign Dout7  = r_lanes[7];
    assign Dout8  = r_lanes[8];
    assign Dout9  = r_lanes[9];
    assign Dout10 = r_lanes[10];
    assign Dout11 = r_lanes[11];
    assign Dout12 = r_lanes[12];
    assign Dout13 = r_lanes[13];
    assign Dout14 = r_lanes[14];
    assign Dout15 = r_lanes[15];
    assign valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_lea_128bits_divide_in_16x8_register.sv
`default_nettype none
//============================================================================
// Module  : tb_lea_128bits_divide_in_16x8_register
// Purpose : Randomized self-checking bench for the 128-bit to 16x8 register.
// Revision: 1.0 - initial release
//============================================================================
module tb_lea_128bits_divide_in_16x8_register;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [127:0] din;
    logic [7:0]   d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0]   d8, d9, d10, d11, d12, d13, d14, d15;
    logic         valid;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [127:0] model_blk;
    logic         model_valid;
    logic [127:0] dout_bus;

    always #5 clk = ~clk;

    assign dout_bus = {d15, d14, d13, d12, d11, d10, d9, d8,
                       d7, d6, d5, d4, d3, d2, d1, d0};

    lea_128bits_divide_in_16x8_register dut (
        .clk(clk), .rst_n(rst_n), .load(load), .Din(din),
        .Dout0(d0), .Dout1(d1), .Dout2(d2), .Dout3(d3),
        .Dout4(d4), .Dout5(d5), .Dout6(d6), .Dout7(d7),
        .Dout8(d8), .Dout9(d9), .Dout10(d10), .Dout11(d11),
        .Dout12(d12), .Dout13(d13), .Dout14(d14), .Dout15(d15),
        .valid(valid)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lane(input logic [127:0] blk, input int k);
        return 8'((blk >> (8 * k)) & 128'hFF);
    endfunction

    // Every lane against the model's byte k, plus valid.
    task automatic check_all(input string tag);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s lane%0d", tag, k), 128'(lane(dout_bus, k)), 128'(lane(model_blk, k)));
        check($sformatf("%s valid", tag), 128'(valid), 128'(model_valid));
    endtask

    // One rising edge; the model captures what the DUT sees at that edge.
    task automatic cycle();
        logic         cap;
        logic [127:0] d;
        cap = load && rst_n;
        d   = din;
        @(posedge clk);
        if (cap) begin
            model_blk   = d;
            model_valid = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        load        = 1'b1;
        din         = '1;
        model_blk   = '0;
        model_valid = 1'b0;

        #1;
        check_all("reset_immediate");
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all("reset_held");
        end

        load  = 1'b0;
        rst_n = 1'b1;
        cycle();
        check_all("after_release");

        din  = 128'h3F775928F3133EDB0D3DB1D50F29E928;
        load = 1'b1;
        cycle();
        load = 1'b0;
        check_all("single_load");
        check("single_dout0", 128'(d0), 128'h28);
        check("single_dout8", 128'(d8), 128'hDB);
        check("single_dout15", 128'(d15), 128'h3F);

        din = 128'hFFEC9BEA0834015022BED80C66A0FC62;
        for (int i = 0; i < 10; i++) cycle();
        check_all("hold");
        check("hold_dout0", 128'(d0), 128'h28);

        load = 1'b1;
        cycle();
        check_all("b2b_first");
        check("b2b1_dout0", 128'(d0), 128'h62);
        check("b2b1_dout15", 128'(d15), 128'hFF);
        din = 128'h626D4D5D43DF02A34901A2B62CEDDADA;
        cycle();
        load = 1'b0;
        check_all("b2b_second");
        check("b2b2_dout0", 128'(d0), 128'hDA);
        check("b2b2_dout15", 128'(d15), 128'h62);

        @(negedge clk);
        rst_n       = 1'b0;
        model_blk   = '0;
        model_valid = 1'b0;
        #1;
        check_all("async_reset");
        #2;
        rst_n = 1'b1;
        din   = 128'h000102030405060708090A0B0C0D0E0F;
        load  = 1'b1;
        cycle();
        load  = 1'b0;
        check_all("post_reset_load");
        for (int k = 0; k < 16; k++)
            check($sformatf("ramp lane%0d", k), 128'(lane(dout_bus, k)), 128'(8'h0F - 8'(k)));

        for (int n = 0; n < 100; n++) begin
            din  = {$urandom, $urandom, $urandom, $urandom};
            load = 1'b1;
            cycle();
            load = 1'b0;
            check_all($sformatf("rand%0d", n));
            din = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(1, 10)) cycle();
            check_all($sformatf("rand%0d_hold", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
